// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - fixed-priority interrupt arbiter with ack timeout and single in-service slot
module irq_arbiter #(
  parameter int N_SRC       = 2,
  parameter int IRQ_W       = 2,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] pIrq,
  output logic [N_SRC-1:0] pIack,
  output logic [N_SRC-1:0] pIend,
  output logic [IRQ_W-1:0] irq,
  input  logic             iack,
  input  logic             iend,
  output logic             busy,
  output logic             irq_missed
);

  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, PENDING, SERVICE, DONE} state_t;

  state_t           state, stateNext;
  logic [SRC_W-1:0] src, srcNext, winner;
  logic             anyReq;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [N_SRC-1:0] pIackNext, pIendNext;
  logic [IRQ_W-1:0] irqNext;
  logic             missedNext;

  // Scan from the top down so the lowest-index request is the one left standing.
  always_comb begin
    winner = '0;
    anyReq = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pIrq[i]) begin
        winner = SRC_W'(i);
        anyReq = 1'b1;
      end
    end
  end

  always_comb begin
    stateNext  = state;
    srcNext    = src;
    cntNext    = cnt;
    irqNext    = irq;
    pIackNext  = '0;
    pIendNext  = '0;
    missedNext = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) begin
          srcNext   = winner;
          cntNext   = '0;
          irqNext   = IRQ_W'(winner) + IRQ_W'(1);
          stateNext = PENDING;
        end
      end
      PENDING: begin
        if (iack) begin
          pIackNext[src] = 1'b1;
          irqNext        = '0;
          stateNext      = SERVICE;
        end else if (!pIrq[src]) begin
          irqNext   = '0;
          stateNext = IDLE;
        end else if (cnt == CNT_W'(ACK_TIMEOUT)) begin
          irqNext    = '0;
          missedNext = 1'b1;
          stateNext  = IDLE;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      SERVICE: begin
        if (iend) begin
          pIendNext[src] = 1'b1;
          stateNext      = DONE;
        end
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      src        <= '0;
      cnt        <= '0;
      irq        <= '0;
      pIack      <= '0;
      pIend      <= '0;
      busy       <= 1'b0;
      irq_missed <= 1'b0;
    end else begin
      state      <= stateNext;
      src        <= srcNext;
      cnt        <= cntNext;
      irq        <= irqNext;
      pIack      <= pIackNext;
      pIend      <= pIendNext;
      busy       <= (stateNext != IDLE);
      irq_missed <= missedNext;
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - directed and randomized checks of irq_arbiter against a transaction-level model
module tb_irq_arbiter;

  localparam int T = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] pIrq = '0;
  logic [1:0] pIack, pIend, irq;
  logic       iack = 1'b0, iend = 1'b0, busy, irq_missed;

  int tests = 0;
  int fails = 0;

  // Model: who owns the processor's attention and what it is doing with it.
  int         owner = -1;
  string      phase = "free";
  int         age = 0;
  logic [1:0] eIrq = '0, eAck = '0, eEnd = '0;
  logic       eBusy = 1'b0, eMiss = 1'b0;

  irq_arbiter #(.N_SRC(2), .IRQ_W(2), .ACK_TIMEOUT(T)) dut (
    .CLK(CLK), .RESET(RESET), .pIrq(pIrq), .pIack(pIack), .pIend(pIend),
    .irq(irq), .iack(iack), .iend(iend), .busy(busy), .irq_missed(irq_missed)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic modelEdge(input logic [1:0] r, input logic a, input logic e, input logic rst);
    eAck  = '0;
    eEnd  = '0;
    eMiss = 1'b0;
    if (rst) begin
      phase = "free"; owner = -1; eIrq = '0;
    end else if (phase == "free") begin
      if (r != 0) begin
        owner = r[0] ? 0 : 1;
        age   = 0;
        eIrq  = 2'(owner + 1);
        phase = "offered";
      end
    end else if (phase == "offered") begin
      if (a) begin
        eAck  = 2'(1 << owner);
        eIrq  = '0;
        phase = "serving";
      end else if (!r[owner]) begin
        eIrq  = '0;
        phase = "free";
      end else if (age == T) begin
        eIrq  = '0;
        eMiss = 1'b1;
        phase = "free";
      end else begin
        age++;
      end
    end else if (phase == "serving") begin
      if (e) begin
        eEnd  = 2'(1 << owner);
        phase = "closing";
      end
    end else begin
      phase = "free";
    end
    eBusy = (phase != "free");
  endtask

  task automatic step(input logic [1:0] r, input logic a = 1'b0, input logic e = 1'b0,
                      input logic rst = 1'b0);
    pIrq = r; iack = a; iend = e; RESET = rst;
    @(posedge CLK);
    modelEdge(r, a, e, rst);
    #1;
    chk("irq", 32'(irq), 32'(eIrq));
    chk("pIack", 32'(pIack), 32'(eAck));
    chk("pIend", 32'(pIend), 32'(eEnd));
    chk("busy", 32'(busy), 32'(eBusy));
    chk("irq_missed", 32'(irq_missed), 32'(eMiss));
  endtask

  logic [1:0] rq;

  initial begin
    #2;
    step(2'b00, 0, 0, 1);
    step(2'b00, 0, 0, 1);
    chk("reset_irq", 32'(irq), 0);
    chk("reset_busy", 32'(busy), 0);

    // Keyboard request, acked three cycles later, then serviced.
    step(2'b10);
    chk("kb_irq", 32'(irq), 2);
    step(2'b10); step(2'b10);
    step(2'b10, 1);
    chk("kb_pIack", 32'(pIack), 2'b10);
    step(2'b00);
    step(2'b00, 0, 1);
    chk("kb_pIend", 32'(pIend), 2'b10);
    step(2'b00); step(2'b00);
    chk("kb_idle_busy", 32'(busy), 0);

    // Simultaneous requests: timer first, keyboard two cycles after pIend.
    step(2'b11);
    chk("both_irq", 32'(irq), 1);
    step(2'b11, 1);
    step(2'b10);
    step(2'b10, 0, 1);
    step(2'b10); step(2'b10);
    chk("kb_after_timer", 32'(irq), 2);
    step(2'b10, 1); step(2'b00); step(2'b00, 0, 1); step(2'b00); step(2'b00);

    // No preemption of a latched keyboard request.
    step(2'b10);
    step(2'b11); step(2'b11);
    chk("no_preempt", 32'(irq), 2);
    step(2'b11, 1); step(2'b01, 0, 1); step(2'b01); step(2'b01);
    chk("timer_later", 32'(irq), 1);
    step(2'b01, 1); step(2'b00); step(2'b00, 0, 1); step(2'b00); step(2'b00);

    // Ack timeout then re-presentation after one idle cycle.
    step(2'b01);
    repeat (4) step(2'b01);
    chk("pre_timeout_irq", 32'(irq), 1);
    step(2'b01);
    chk("timeout_missed", 32'(irq_missed), 1);
    step(2'b01);
    chk("represent_irq", 32'(irq), 1);
    step(2'b00); step(2'b00);

    // Withdrawal; then iack and iend together.
    step(2'b10);
    step(2'b00);
    chk("withdraw_irq", 32'(irq), 0);
    chk("withdraw_missed", 32'(irq_missed), 0);
    step(2'b10);
    step(2'b10, 1, 1);
    chk("ackend_pIack", 32'(pIack), 2'b10);
    chk("ackend_pIend", 32'(pIend), 0);
    step(2'b00, 0, 1); step(2'b00); step(2'b00);

    // Stray strobes and reset during service.
    step(2'b00, 0, 1);
    chk("stray_iend", 32'(pIend), 0);
    step(2'b01); step(2'b01, 1);
    step(2'b00, 1);
    chk("stray_iack", 32'(pIack), 0);
    step(2'b00, 0, 1, 1);
    chk("rst_busy", 32'(busy), 0);
    step(2'b00, 0, 1);
    chk("rst_no_pIend", 32'(pIend), 0);
    step(2'b00);

    // Randomized traffic with sticky request levels.
    rq = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 2'($urandom_range(0, 3));
      step(rq, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
